vga_sync_decoder: RTL

- Receive-side counterpart of the VGA timing generator: consumes active-low hsync/vsync for 640x480@60 (800x525 total) and recovers pixel position, visible window and frame boundaries.
- Sits in capture and loopback paths: the bench drives it from the timer's sync outputs, and downstream consumers use its recovered coordinates.
- Verifies every sync edge against expected timing, reports lock and sync errors.

---
 rtl/vga_sync_decoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : Recovers pixel position, visible window and frame boundaries from
//            active-low hsync/vsync, checks every sync edge against the
//            expected timing and reports lock and timing violations.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] position_x_o,
  output logic [9:0] position_y_o,
  output logic       visible_o,
  output logic       locked_o,
  output logic       frame_start_o,
  output logic       sync_err_o,
  output logic [7:0] err_count_o
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [9:0] X_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_HS_START   = 10'(HS_START);
  localparam logic [9:0] X_HS_PRE     = 10'(HS_START - 1);
  localparam logic [9:0] X_HS_END_PRE = 10'(HS_END - 1);
  localparam logic [9:0] X_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_VS_START   = 10'(VS_START);
  localparam logic [9:0] Y_VS_PRE     = 10'(VS_START - 1);
  localparam logic [9:0] Y_VS_END_PRE = 10'(VS_END - 1);
  localparam logic [9:0] Y_VIS        = 10'(V_VISIBLE);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    H_ALIGN = 2'd1,
    V_ALIGN = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        locked_q;
  logic        sync_err_q;
  logic [7:0]  err_count_q, err_count_d;
  logic        viol;

  // Edge detection against the one-cycle sync history.
  logic hs_fall, hs_rise, vs_fall, vs_rise;
  assign hs_fall = hs_q & ~hsync_i;
  assign hs_rise = ~hs_q & hsync_i;
  assign vs_fall = vs_q & ~vsync_i;
  assign vs_rise = ~vs_q & vsync_i;

  // Position qualifiers used by the edge checks.
  logic x_at_last, x_at_hs_pre, x_at_hs_end_pre, y_at_vs_pre, y_at_vs_end_pre;
  assign x_at_last       = (x_q == X_LAST);
  assign x_at_hs_pre     = (x_q == X_HS_PRE);
  assign x_at_hs_end_pre = (x_q == X_HS_END_PRE);
  assign y_at_vs_pre     = (y_q == Y_VS_PRE);
  assign y_at_vs_end_pre = (y_q == Y_VS_END_PRE);

  // Grouped violation terms; which groups apply depends on the state.
  logic hs_bad, vs_x_bad, vs_y_bad, edge_missing;
  assign hs_bad       = (hs_fall & ~x_at_hs_pre) | (hs_rise & ~x_at_hs_end_pre);
  assign vs_x_bad     = (vs_fall | vs_rise) & ~x_at_last;
  assign vs_y_bad     = (vs_fall & ~y_at_vs_pre) | (vs_rise & ~y_at_vs_end_pre);
  assign edge_missing = (x_at_hs_pre & ~hs_fall) |
                        (x_at_last & y_at_vs_pre & ~vs_fall);

  // Position counters: sync falls realign, otherwise free-run with wrap.
  always_comb begin
    x_d = (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (hs_fall) begin
      x_d = X_HS_START;
    end
    if (vs_fall) begin
      y_d = Y_VS_START;
    end else if (x_at_last) begin
      y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
    end
  end

  // Lock FSM: state-dependent violation detection and next state.
  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (hs_fall) state_d = H_ALIGN;
      end
      H_ALIGN: begin
        viol = hs_bad | vs_x_bad;
        if (viol)         state_d = SEARCH;
        else if (vs_fall) state_d = V_ALIGN;
      end
      V_ALIGN: begin
        viol = hs_bad | vs_x_bad | vs_y_bad;
        if (viol)         state_d = SEARCH;
        else if (vs_fall) state_d = LOCKED;
      end
      LOCKED: begin
        viol = hs_bad | vs_x_bad | vs_y_bad | edge_missing;
        if (viol) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Saturating violation counter; simultaneous violations count once.
  always_comb begin
    err_count_d = err_count_q;
    if (viol && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State, history, counters and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hsync_i;
      vs_q        <= vsync_i;
      x_q         <= x_d;
      y_q         <= y_d;
      locked_q    <= (state_d == LOCKED);
      sync_err_q  <= viol;
      err_count_q <= err_count_d;
    end
  end

  assign position_x_o  = x_q;
  assign position_y_o  = y_q;
  assign locked_o      = locked_q;
  assign sync_err_o    = sync_err_q;
  assign err_count_o   = err_count_q;
  assign visible_o     = locked_q & (x_q < X_VIS) & (y_q < Y_VIS);
  assign frame_start_o = locked_q & (x_q == 10'd0) & (y_q == 10'd0);

endmodule
`default_nettype wire
